fpu_conv_issue: RTL and testbench
=================================

Name: fpu_conv_issue

Overview:
Issue/writeback controller for the FPU conversion path (float→int and int→float). It accepts conversion requests over a valid/ready handshake and drives the shared operand into the free-running, fixed-latency converter datapaths. Destination tag and op travel through a latency-matched pipeline, and results are captured into a small writeback FIFO. Credit accounting guarantees that no converter result is ever dropped, because the converters have no stall input.

Parameters:
CONV_LAT, 2, converter latency in clock edges from operand sample to registered result (both converters identical)
DEPTH, 4, writeback FIFO entries; also the max outstanding requests (in-flight + buffered)
TAG_W, 5, destination register tag width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
flush  in  1  synchronous kill of all in-flight and buffered results
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready
req_op  in  1  0 = ftoi, 1 = itof
req_rd  in  TAG_W  destination tag
req_operand  in  32  source operand
conv_a  out  32  operand to both converters; equals req_operand combinationally
ftoi_res  in  32  float→int converter registered result
itof_res  in  32  int→float converter registered result
wb_valid  out  1  FIFO head valid
wb_ready  in  1  writeback consumer ready
wb_rd  out  TAG_W  head tag
wb_data  out  32  head result
busy  out  1  high when outstanding count != 0

Behaviour:
- Reset (async): tag pipeline valids = 0, FIFO empty, pointers = 0, outstanding = 0. Outputs: wb_valid=0, wb_rd=0, wb_data=0, busy=0. req_ready is comb and is 1 after reset unless flush=1.
- fire = req_valid & req_ready; pop = wb_valid & wb_ready.
- req_ready = !flush & (outstanding < DEPTH). No same-cycle credit return: a pop in cycle t does not raise req_ready until t+1.
- outstanding counter, width $clog2(DEPTH+1): +fire −pop each edge; both at once → unchanged; flush → 0.
- conv_a = req_operand, ungated. The converters sample it every edge, and the value only matters when fire=1.
- Tag pipeline: CONV_LAT stages of {valid, op, rd}. Stage 0 loads {fire, req_op, req_rd} at the edge ending the fire cycle. Each stage then shifts one per edge.
- The last stage aligns with the converter output: while it is valid, the result mux selects ftoi_res (op=0) or itof_res (op=1). {rd, result} is written to the FIFO at that edge.
- Timing: fire in cycle t → FIFO write at edge ending t+CONV_LAT → wb_valid high in cycle t+CONV_LAT+1 (t+3 default) if FIFO was empty. No bypass.
- Throughput is one request per cycle while credits remain.
- FIFO is in-order: wb_rd/wb_data show the head and hold stable while wb_valid & !wb_ready.
  - Pointers wrap modulo DEPTH.
  - Simultaneous write and pop is legal at any occupancy, including full (credits guarantee no overflow) and empty-with-write (pop only when already valid).
  - Overflow is impossible by construction; the bench asserts it.
- flush: clears all pipeline valids, empties the FIFO, zeroes outstanding at that edge. A fire in the same cycle is impossible (req_ready=0). wb_valid=0 from the next cycle. Converter outputs from killed ops are ignored.
- Reset mid-operation: all state is discarded immediately. No result from before reset may appear on wb after release.
- wb_data when !wb_valid: holds the last value, is 0 after reset, and is don't-care for consumers.

Decomposition:
- fpu_pkg holds:
  - conv_op_e enum {CONV_FTOI=0, CONV_ITOF=1}
  - CONV_LAT localparam
  - struct conv_tag_t {valid, op, rd}
  - struct wb_entry_t {rd, data}
- One sub-module: fpu_wb_fifo, a parameterised synchronous FIFO with flush and with count output used for assertions.
- The tag pipeline and credit counter stay in the top module.

Test Plan:
1. Single ftoi: fire op=0, rd=5, operand 0x3FC00000 (1.5) in cycle t, wb_ready=1 → in cycle t+3 exactly: wb_valid=1, wb_rd=5, wb_data=0x00000002; busy falls at t+4.
2. itof back-to-back with ftoi: cycle t itof rd=1 operand 0x00000003, cycle t+1 ftoi rd=2 operand 0xC0200000 (−2.5) → wb (1, 0x40400000) at t+3, then (2, 0xFFFFFFFD) at t+4, in order.
3. Backpressure/full: wb_ready=0, req_valid=1 continuously → exactly 4 fires, req_ready=0 from the 5th cycle. Head holds (rd, data) stable. Raise wb_ready for one cycle → one pop; req_ready=1 the next cycle; the 5th request completes 3 cycles after its fire.
4. Simultaneous fire and pop at outstanding=DEPTH−1 → count unchanged, no overflow assertion, order preserved across pointer wrap (run ≥10 requests with random wb_ready; output sequence equals input sequence).
5. Flush with 2 in flight and 2 buffered → next cycle wb_valid=0, busy=0, req_ready=1. No stale result appears in the following 5 cycles. A new request after flush returns correctly at t+3.
6. Assert rst_n low mid-stream (3 outstanding) → all outputs at reset values while low. After release, a fresh request rd=7 returns only its own result; no earlier tag is observed.

Source files
------------

// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_pkg
//  Purpose  : Shared types and constants for the FPU conversion issue path:
//             converter op encoding, tag pipeline stage, writeback entry.
//  Revision : 1.0  initial release
// ============================================================================
package fpu_pkg;

    // Latency of both converters, in edges from operand sample to result
    localparam int unsigned CONV_LAT = 2;

    // Destination register tag width
    localparam int unsigned TAG_W = 5;

    typedef enum logic {
        CONV_FTOI = 1'b0,
        CONV_ITOF = 1'b1
    } conv_op_e;

    // One stage of the latency-matched tag pipeline
    typedef struct packed {
        logic             valid;
        conv_op_e         op;
        logic [TAG_W-1:0] rd;
    } conv_tag_t;

    // One writeback FIFO entry
    typedef struct packed {
        logic [TAG_W-1:0] rd;
        logic [31:0]      data;
    } wb_entry_t;

endpackage : fpu_pkg
`default_nettype wire

// File: rtl/fpu_wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_wb_fifo
//  Purpose  : Small in-order synchronous FIFO with synchronous flush and an
//             occupancy output. The head is shown combinationally; when empty
//             the output holds the last head value shown.
//  Revision : 1.0  initial release
// ============================================================================
module fpu_wb_fifo #(
    parameter  int unsigned WIDTH = 37,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_rd,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_hold;
    logic             w_valid;
    logic             w_pop;
    logic [WIDTH-1:0] w_head;

    // Pointer advance with wrap at DEPTH (DEPTH need not be a power of two)
    function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_valid = (r_count != '0);
    assign w_pop   = i_rd & w_valid;
    assign w_head  = r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping; flush empties the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_wr) begin
                r_wr_ptr <= f_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_next(r_rd_ptr);
            end
            r_count <= r_count + CNT_W'(i_wr) - CNT_W'(w_pop);
        end
    end

    // Entry storage; no reset needed since only valid slots are ever shown
    always_ff @(posedge clk) begin
        if (i_wr && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Remember the last head shown so the output is stable while empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= '0;
        end else if (w_valid) begin
            r_hold <= w_head;
        end
    end

    // Head presentation
    always_comb begin
        o_valid = w_valid;
        o_rdata = w_valid ? w_head : r_hold;
        o_count = r_count;
    end

endmodule : fpu_wb_fifo
`default_nettype wire

// File: rtl/fpu_conv_issue.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_conv_issue
//  Purpose  : Issue/writeback controller for the FPU conversion path. Drives
//             the shared operand into the free-running fixed-latency
//             converters, carries {valid, op, rd} through a latency-matched
//             pipeline and captures results in a writeback FIFO. Credits
//             bound outstanding work to the FIFO depth so that no converter
//             result can ever be dropped.
//  Revision : 1.0  initial release
// ============================================================================
module fpu_conv_issue
    import fpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_op,
    input  logic [TAG_W-1:0] req_rd,
    input  logic [31:0]      req_operand,
    output logic [31:0]      conv_a,
    input  logic [31:0]      ftoi_res,
    input  logic [31:0]      itof_res,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [TAG_W-1:0] wb_rd,
    output logic [31:0]      wb_data,
    output logic             busy
);

    localparam int unsigned     CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    conv_tag_t        r_tag [CONV_LAT];
    logic [CNT_W-1:0] r_outstanding;
    logic             w_fire;
    logic             w_pop;
    conv_tag_t        w_last;
    logic [31:0]      w_result;
    wb_entry_t        w_wr_entry;
    wb_entry_t        w_head;
    logic             w_fifo_valid;
    logic [CNT_W-1:0] w_fifo_count;

    // Handshake and credit gating; a pop only returns its credit next cycle
    always_comb begin
        req_ready = !flush && (r_outstanding < C_DEPTH);
        w_fire    = req_valid & req_ready;
        w_pop     = w_fifo_valid & wb_ready;
        conv_a    = req_operand;
        busy      = (r_outstanding != '0);
    end

    // Outstanding counter: requests in flight plus buffered results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outstanding <= '0;
        end else if (flush) begin
            r_outstanding <= '0;
        end else begin
            case ({w_fire, w_pop})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // Tag pipeline, one stage per converter edge; flush kills every stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(CONV_LAT); i++) begin
                r_tag[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < int'(CONV_LAT); i++) begin
                r_tag[i].valid <= 1'b0;
            end
        end else begin
            r_tag[0] <= '{valid: w_fire, op: conv_op_e'(req_op), rd: req_rd};
            for (int i = 1; i < int'(CONV_LAT); i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    // Last stage lines up with the converter outputs: pick the matching one
    always_comb begin
        w_last     = r_tag[CONV_LAT-1];
        w_result   = (w_last.op == CONV_ITOF) ? itof_res : ftoi_res;
        w_wr_entry = '{rd: w_last.rd, data: w_result};
    end

    fpu_wb_fifo #(
        .WIDTH ($bits(wb_entry_t)),
        .DEPTH (DEPTH)
    ) u_wb_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (flush),
        .i_wr    (w_last.valid),
        .i_wdata (w_wr_entry),
        .i_rd    (wb_ready),
        .o_valid (w_fifo_valid),
        .o_rdata (w_head),
        .o_count (w_fifo_count)
    );

    // Writeback presentation straight from the FIFO head
    always_comb begin
        wb_valid = w_fifo_valid;
        wb_rd    = w_head.rd;
        wb_data  = w_head.data;
    end

    // Credits must make a write into a full FIFO without a pop impossible
    always_ff @(posedge clk) begin
        if (rst_n && !flush) begin
            assert (!(w_last.valid && !w_pop && (w_fifo_count == C_DEPTH)));
        end
    end

endmodule : fpu_conv_issue
`default_nettype wire

// File: tb/tb_fpu_conv_issue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fpu_conv_issue
//  Purpose  : Self-checking bench for fpu_conv_issue with converter models,
//             an outstanding-count model and an in-order scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fpu_conv_issue;
    import fpu_pkg::*;

    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_op = 1'b0;
    logic [TAG_W-1:0] req_rd = '0;
    logic [31:0]      req_operand = '0;
    logic             wb_ready = 1'b0;
    logic             req_ready;
    logic [31:0]      conv_a;
    logic [31:0]      ftoi_res;
    logic [31:0]      itof_res;
    logic             wb_valid;
    logic [TAG_W-1:0] wb_rd;
    logic [31:0]      wb_data;
    logic             busy;

    typedef struct {
        logic [TAG_W-1:0] rd;
        logic [31:0]      data;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_vec = 0;
    int   n_err = 0;
    int   m_out = 0;

    always #5 clk = ~clk;

    fpu_conv_issue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_rd      (req_rd),
        .req_operand (req_operand),
        .conv_a      (conv_a),
        .ftoi_res    (ftoi_res),
        .itof_res    (itof_res),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .busy        (busy)
    );

    // float -> int, rounding half away from zero, saturating
    function automatic logic [31:0] m_ftoi(input logic [31:0] f);
        int  ex;
        int  k;
        real r;
        if (f[30:23] == 8'd0) return 32'd0;
        ex = int'(f[30:23]) - 127;
        if (ex >= 31) return f[31] ? 32'h80000000 : 32'h7FFFFFFF;
        r = 1.0 + real'(f[22:0]) / 8388608.0;
        if (ex >= 0) begin
            for (int i = 0; i < ex; i++) r = r * 2.0;
        end else begin
            for (int i = 0; i < -ex; i++) r = r / 2.0;
        end
        k = $rtoi(r + 0.5);
        return f[31] ? 32'(-k) : 32'(k);
    endfunction

    // int -> float, exact below 2^24, truncating above
    function automatic logic [31:0] m_itof(input logic [31:0] x);
        logic        s;
        logic [31:0] mag;
        logic [31:0] mn;
        int          p;
        if (x == 32'd0) return 32'd0;
        s   = x[31];
        mag = s ? (~x + 32'd1) : x;
        p   = 0;
        for (int b = 0; b < 32; b++) if (mag[b]) p = b;
        if (p <= 23) mn = mag << (23 - p);
        else         mn = mag >> (p - 23);
        return {s, 8'(p + 127), mn[22:0]};
    endfunction

    // Converter models: two registered stages each
    logic [31:0] r_f1, r_f2, r_i1, r_i2;
    always @(posedge clk) begin
        r_f1 <= m_ftoi(conv_a);
        r_f2 <= r_f1;
        r_i1 <= m_itof(conv_a);
        r_i2 <= r_i1;
    end
    assign ftoi_res = r_f2;
    assign itof_res = r_i2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic op, input logic [TAG_W-1:0] rd, input logic [31:0] opnd);
        req_valid   = 1'b1;
        req_op      = op;
        req_rd      = rd;
        req_operand = opnd;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 300) begin
            step();
            k++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
        chk({tag, "_wb_rd"}, 32'(wb_rd), 32'd0);
        chk({tag, "_wb_data"}, wb_data, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    endtask

    // Scoreboard and outstanding-count model, evaluated mid-cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_out = 0;
        end else begin
            chk("ready_model", 32'(req_ready), 32'(!flush && (m_out < DEPTH)));
            chk("busy_model", 32'(busy), 32'(m_out != 0));
            chk("fifo_ovf", 32'(int'(dut.w_fifo_count) <= DEPTH), 32'd1);
            if (q.size() == 0) begin
                chk("spurious_wb", 32'(wb_valid), 32'd0);
            end else if (wb_valid && wb_ready) begin
                e = q.pop_front();
                chk("sb_rd", 32'(wb_rd), 32'(e.rd));
                chk("sb_data", wb_data, e.data);
            end
            if (flush) m_out = 0;
            else m_out = m_out + int'(req_valid && req_ready) - int'(wb_valid && wb_ready);
            if (flush) q.delete();
            if (req_valid && req_ready) begin
                q.push_back('{rd: req_rd, data: req_op ? m_itof(req_operand) : m_ftoi(req_operand)});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int idx;
        int sent;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outs("rst");
        step();
        rst_n = 1'b1;
        wb_ready = 1'b1;
        step();

        // 1: single ftoi, result visible exactly three cycles after fire
        set_req(1'b0, 5'd5, 32'h3FC00000);
        @(negedge clk);
        chk("t1_fire", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k < 3) chk("t1_early", 32'(wb_valid), 32'd0);
            if (k == 3) begin
                chk("t1_valid", 32'(wb_valid), 32'd1);
                chk("t1_rd", 32'(wb_rd), 32'd5);
                chk("t1_data", wb_data, 32'h00000002);
                chk("t1_busy_hi", 32'(busy), 32'd1);
            end
            if (k == 4) begin
                chk("t1_busy_lo", 32'(busy), 32'd0);
                chk("t1_valid_lo", 32'(wb_valid), 32'd0);
            end
            step();
        end

        // 2: itof then ftoi back to back, in order
        set_req(1'b1, 5'd1, 32'h00000003);
        @(negedge clk);
        chk("t2_fire0", 32'(req_ready), 32'd1);
        step();
        set_req(1'b0, 5'd2, 32'hC0200000);
        @(negedge clk);
        chk("t2_fire1", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        @(negedge clk);
        chk("t2_early", 32'(wb_valid), 32'd0);
        step();
        @(negedge clk);
        chk("t2_v0", 32'(wb_valid), 32'd1);
        chk("t2_rd0", 32'(wb_rd), 32'd1);
        chk("t2_d0", wb_data, 32'h40400000);
        step();
        @(negedge clk);
        chk("t2_v1", 32'(wb_valid), 32'd1);
        chk("t2_rd1", 32'(wb_rd), 32'd2);
        chk("t2_d1", wb_data, 32'hFFFFFFFD);
        step();
        wait_idle();

        // 3: backpressure until full, head stable, one pop returns one credit
        wb_ready = 1'b0;
        idx = 0;
        for (int k = 1; k <= 8; k++) begin
            set_req(1'(idx % 2), 5'(8 + idx),
                    (idx % 2 == 1) ? 32'((idx + 1) * 3) : m_itof(32'((idx + 1) * 5)));
            @(negedge clk);
            chk("t3_ready", 32'(req_ready), 32'(k <= 4));
            if (req_ready) idx++;
            if (k >= 4) begin
                chk("t3_head_v", 32'(wb_valid), 32'd1);
                chk("t3_head_rd", 32'(wb_rd), 32'd8);
                chk("t3_head_d", wb_data, 32'd5);
            end
            step();
        end
        chk("t3_fires", 32'(idx), 32'd4);
        wb_ready = 1'b1;
        @(negedge clk);
        chk("t3_full_ready", 32'(req_ready), 32'd0);
        step();
        wb_ready = 1'b0;
        @(negedge clk);
        chk("t3_credit_ready", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            chk("t3_cnt", 32'(dut.w_fifo_count), (k == 4) ? 32'd4 : 32'd3);
            step();
        end
        wb_ready = 1'b1;
        wait_idle();

        // 4: random traffic and random backpressure across pointer wrap
        sent = 0;
        for (int c = 0; c < 400 && sent < 30; c++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_op    = 1'($urandom_range(0, 1));
            req_rd    = 5'($urandom);
            req_operand = req_op ? $urandom
                                 : m_itof(32'(int'($urandom_range(0, 1000)) - 500));
            wb_ready  = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (req_valid && req_ready) sent++;
            step();
        end
        req_valid = 1'b0;
        wb_ready  = 1'b1;
        chk("t4_sent", 32'(sent), 32'd30);
        wait_idle();

        // 5: flush with two in flight and two buffered
        wb_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_req(1'b0, 5'(16 + i), m_itof(32'(i + 1)));
            @(negedge clk);
            chk("t5_fire", 32'(req_ready), 32'd1);
            step();
        end
        req_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        chk("t5_flush_ready", 32'(req_ready), 32'd0);
        chk("t5_buffered", 32'(dut.w_fifo_count), 32'd2);
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("t5_wb_valid", 32'(wb_valid), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_ready", 32'(req_ready), 32'd1);
        step();
        wb_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t5_stale", 32'(wb_valid), 32'd0);
            step();
        end
        set_req(1'b1, 5'd3, 32'd10);
        @(negedge clk);
        chk("t5_new_fire", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k < 3) chk("t5_new_early", 32'(wb_valid), 32'd0);
            if (k == 3) begin
                chk("t5_new_v", 32'(wb_valid), 32'd1);
                chk("t5_new_rd", 32'(wb_rd), 32'd3);
                chk("t5_new_d", wb_data, 32'h41200000);
            end
            step();
        end
        wait_idle();

        // 6: reset with three outstanding, then a fresh request
        wb_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_req(1'b0, 5'(20 + i), m_itof(32'(i + 11)));
            @(negedge clk);
            chk("t6_fire", 32'(req_ready), 32'd1);
            step();
        end
        req_valid = 1'b0;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk_reset_outs("t6_rst");
            step();
        end
        rst_n = 1'b1;
        wb_ready = 1'b1;
        @(negedge clk);
        chk("t6_rel_valid", 32'(wb_valid), 32'd0);
        step();
        set_req(1'b0, 5'd7, 32'h40E00000);
        @(negedge clk);
        chk("t6_fire7", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 3) begin
                chk("t6_v", 32'(wb_valid), 32'd1);
                chk("t6_rd", 32'(wb_rd), 32'd7);
                chk("t6_d", wb_data, 32'd7);
            end else begin
                chk("t6_only_own", 32'(wb_valid), 32'd0);
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_fpu_conv_issue
`default_nettype wire
